// File: rtl/regfile_sb_if.sv
// Register file bus: operand read ports, issue (busy marking) and writeback.
// The register file is the slave; the pipeline driving it is the master.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW:0]     busy_cnt;

    modport slave (
        output ready, rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt,
        input  rs1, rs2, we, rd, rd_data, iss_valid, iss_rd
    );

    modport master (
        input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy, busy_cnt,
        output rs1, rs2, we, rd, rd_data, iss_valid, iss_rd
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with pending-writeback scoreboard, optional
// write-to-read bypass and a post-reset sequential clear of the array.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            ready_q;
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [NREG];

    logic            run, set, clr, inc, dec;
    logic            byp1, byp2;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    // Qualified issue/writeback strobes; both are suppressed while clearing.
    always_comb begin
        run = (state_q == RUN);
        set = run && bus.iss_valid && (bus.iss_rd != '0);
        clr = run && bus.we && (bus.rd != '0);
    end

    // Single array write port shared by the clear sequence and writeback.
    always_comb begin
        wr_en   = !run || clr;
        wr_addr = run ? bus.rd : clr_idx_q;
        wr_data = run ? bus.rd_data : '0;
    end

    // Storage array: no reset, so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Clear FSM: walk every entry once after reset, then stay in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else if (state_q == CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(NREG - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Scoreboard next state; set is applied after clr so a same-register
    // issue and retire leaves the bit set and the count unchanged.
    always_comb begin
        busy_d = busy_q;
        if (clr) busy_d[bus.rd] = 1'b0;
        if (set) busy_d[bus.iss_rd] = 1'b1;
        inc   = set && !busy_q[bus.iss_rd];
        dec   = clr && busy_q[bus.rd] && !(set && (bus.iss_rd == bus.rd));
        cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end

    // Scoreboard and busy counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Combinational read ports with x0 forcing and optional bypass.
    always_comb begin
        byp1 = (BYPASS != 0) && clr && (bus.rd == bus.rs1);
        byp2 = (BYPASS != 0) && clr && (bus.rd == bus.rs2);

        if (!run || bus.rs1 == '0) bus.rs1_data = '0;
        else if (byp1)             bus.rs1_data = bus.rd_data;
        else                       bus.rs1_data = mem_q[bus.rs1];

        if (!run || bus.rs2 == '0) bus.rs2_data = '0;
        else if (byp2)             bus.rs2_data = bus.rd_data;
        else                       bus.rs2_data = mem_q[bus.rs2];

        bus.rs1_busy = busy_q[bus.rs1] && !(byp1 && !(set && bus.iss_rd == bus.rs1));
        bus.rs2_busy = busy_q[bus.rs2] && !(byp2 && !(set && bus.iss_rd == bus.rs2));
    end

    assign bus.ready    = ready_q;
    assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance
// driven with identical stimulus.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREG(32)) b1 ();
    regfile_sb_if #(.XLEN(32), .NREG(32)) b0 ();

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    assign b0.rs1       = b1.rs1;
    assign b0.rs2       = b1.rs2;
    assign b0.we        = b1.we;
    assign b0.rd        = b1.rd;
    assign b0.rd_data   = b1.rd_data;
    assign b0.iss_valid = b1.iss_valid;
    assign b0.iss_rd    = b1.iss_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b1.we        = 1'b0;
        b1.iss_valid = 1'b0;
    endtask

    // Wait for ready after reset release; returns edges taken (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (n == 16) begin
                total++; if (b1.rs1_data !== 32'h0) $display("FAIL clear_rd_zero got %h exp %h", b1.rs1_data, 32'h0); else pass_cnt++;
                total++; if (b1.busy_cnt !== 6'd0) $display("FAIL clear_cnt got %0d exp 0", b1.busy_cnt); else pass_cnt++;
            end
            if (n == 31) begin
                b1.we = 1'b0;
                total++; if (b1.ready !== 1'b0) $display("FAIL ready_early got %b exp 0", b1.ready); else pass_cnt++;
            end
            if (b1.ready === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        b1.rs1 = 5'd5; b1.rs2 = 5'd0; b1.rd = 5'd5; b1.rd_data = 32'hFFFF_FFFF; b1.iss_rd = 5'd0;
        #1 rst = 1'b1;
        #2;
        total++; if (b1.ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", b1.ready); else pass_cnt++;
        total++; if (b1.busy_cnt !== 6'd0) $display("FAIL reset_cnt got %0d exp 0", b1.busy_cnt); else pass_cnt++;
        step();
        rst = 1'b0;
        b1.we = 1'b1;   // must be ignored during clear
        wait_ready(n);
        total++; if (n !== 32) $display("FAIL ready_latency got %0d exp 32", n); else pass_cnt++;
        idle();
        #3;
        total++; if (b1.rs1_data !== 32'h0) $display("FAIL x5_after_clear got %h exp %h", b1.rs1_data, 32'h0); else pass_cnt++;
        total++; if (b0.rs1_data !== 32'h0) $display("FAIL x5_after_clear_nb got %h exp %h", b0.rs1_data, 32'h0); else pass_cnt++;
    endtask

    task automatic test_write();
        b1.we = 1'b1; b1.rd = 5'd3; b1.rd_data = 32'hDEAD_BEEF;
        step();
        idle(); b1.rs1 = 5'd3;
        #3;
        total++; if (b1.rs1_data !== 32'hDEAD_BEEF) $display("FAIL write_x3 got %h exp %h", b1.rs1_data, 32'hDEAD_BEEF); else pass_cnt++;
        total++; if (b0.rs1_data !== 32'hDEAD_BEEF) $display("FAIL write_x3_nb got %h exp %h", b0.rs1_data, 32'hDEAD_BEEF); else pass_cnt++;
        b1.we = 1'b1; b1.rd = 5'd0; b1.rd_data = 32'h0000_1234; b1.rs2 = 5'd0;
        #3;
        total++; if (b1.rs2_data !== 32'h0) $display("FAIL x0_bypass got %h exp %h", b1.rs2_data, 32'h0); else pass_cnt++;
        step();
        idle();
        #3;
        total++; if (b1.rs2_data !== 32'h0) $display("FAIL x0_write got %h exp %h", b1.rs2_data, 32'h0); else pass_cnt++;
    endtask

    task automatic test_bypass();
        b1.we = 1'b1; b1.rd = 5'd7; b1.rd_data = 32'hA5A5_A5A5; b1.rs1 = 5'd7;
        #3;
        total++; if (b1.rs1_data !== 32'hA5A5_A5A5) $display("FAIL bypass_on got %h exp %h", b1.rs1_data, 32'hA5A5_A5A5); else pass_cnt++;
        total++; if (b0.rs1_data !== 32'h0) $display("FAIL bypass_off_old got %h exp %h", b0.rs1_data, 32'h0); else pass_cnt++;
        step();
        idle();
        #3;
        total++; if (b0.rs1_data !== 32'hA5A5_A5A5) $display("FAIL bypass_off_new got %h exp %h", b0.rs1_data, 32'hA5A5_A5A5); else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd4;
        step();
        idle(); b1.rs2 = 5'd4;
        #3;
        total++; if (b1.rs2_busy !== 1'b1) $display("FAIL issue_busy got %b exp 1", b1.rs2_busy); else pass_cnt++;
        total++; if (b1.busy_cnt !== 6'd1) $display("FAIL issue_cnt got %0d exp 1", b1.busy_cnt); else pass_cnt++;
        b1.we = 1'b1; b1.rd = 5'd4; b1.rd_data = 32'h44;
        #3;
        total++; if (b1.rs2_busy !== 1'b0) $display("FAIL retire_busy_byp got %b exp 0", b1.rs2_busy); else pass_cnt++;
        total++; if (b0.rs2_busy !== 1'b1) $display("FAIL retire_busy_nobyp got %b exp 1", b0.rs2_busy); else pass_cnt++;
        step();
        idle();
        #3;
        total++; if (b1.rs2_busy !== 1'b0) $display("FAIL wb_busy got %b exp 0", b1.rs2_busy); else pass_cnt++;
        total++; if (b1.busy_cnt !== 6'd0) $display("FAIL wb_cnt got %0d exp 0", b1.busy_cnt); else pass_cnt++;
        // issue and retire the same busy register together
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd9;
        step();
        b1.rs1 = 5'd9; b1.we = 1'b1; b1.rd = 5'd9; b1.rd_data = 32'h99;
        #3;
        total++; if (b1.rs1_busy !== 1'b1) $display("FAIL set_wins_comb got %b exp 1", b1.rs1_busy); else pass_cnt++;
        step();
        idle();
        #3;
        total++; if (b1.rs1_busy !== 1'b1) $display("FAIL set_wins_busy got %b exp 1", b1.rs1_busy); else pass_cnt++;
        total++; if (b1.busy_cnt !== 6'd1) $display("FAIL set_wins_cnt got %0d exp 1", b1.busy_cnt); else pass_cnt++;
        b1.we = 1'b1; b1.rd = 5'd9;
        step();
        // writeback to a non-busy register
        b1.rd = 5'd10; b1.rs2 = 5'd10;
        step();
        idle();
        #3;
        total++; if (b1.busy_cnt !== 6'd0) $display("FAIL untracked_cnt got %0d exp 0", b1.busy_cnt); else pass_cnt++;
        total++; if (b1.rs2_busy !== 1'b0) $display("FAIL untracked_busy got %b exp 0", b1.rs2_busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd1;
        step();
        total++; if (b1.busy_cnt !== 6'd1) $display("FAIL b2b_cnt1 got %0d exp 1", b1.busy_cnt); else pass_cnt++;
        b1.iss_rd = 5'd2;
        step();
        total++; if (b1.busy_cnt !== 6'd2) $display("FAIL b2b_cnt2 got %0d exp 2", b1.busy_cnt); else pass_cnt++;
        b1.iss_rd = 5'd3;
        step();
        total++; if (b1.busy_cnt !== 6'd3) $display("FAIL b2b_cnt3 got %0d exp 3", b1.busy_cnt); else pass_cnt++;
        b1.iss_rd = 5'd6; b1.we = 1'b1; b1.rd = 5'd2; b1.rd_data = 32'h22;
        step();
        idle(); b1.rs1 = 5'd2; b1.rs2 = 5'd6;
        #3;
        total++; if (b1.busy_cnt !== 6'd3) $display("FAIL b2b_cnt4 got %0d exp 3", b1.busy_cnt); else pass_cnt++;
        total++; if (b1.rs1_busy !== 1'b0) $display("FAIL b2b_x2 got %b exp 0", b1.rs1_busy); else pass_cnt++;
        total++; if (b1.rs2_busy !== 1'b1) $display("FAIL b2b_x6 got %b exp 1", b1.rs2_busy); else pass_cnt++;
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd0;
        step();
        total++; if (b1.busy_cnt !== 6'd3) $display("FAIL iss_x0_cnt got %0d exp 3", b1.busy_cnt); else pass_cnt++;
        b1.iss_rd = 5'd6;
        step();
        idle();
        total++; if (b1.busy_cnt !== 6'd3) $display("FAIL reissue_cnt got %0d exp 3", b1.busy_cnt); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int n;
        #3 rst = 1'b1;
        #1;
        total++; if (b1.busy_cnt !== 6'd0) $display("FAIL async_cnt got %0d exp 0", b1.busy_cnt); else pass_cnt++;
        total++; if (b1.ready !== 1'b0) $display("FAIL async_ready got %b exp 0", b1.ready); else pass_cnt++;
        step();
        rst = 1'b0;
        b1.rs1 = 5'd5;
        wait_ready(n);
        total++; if (n !== 32) $display("FAIL restart_latency got %0d exp 32", n); else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            b1.rs1 = 5'(i); b1.rs2 = 5'(i);
            #1;
            total++; if (b1.rs1_data !== 32'h0 || b0.rs2_data !== 32'h0) $display("FAIL cleared_x%0d got %h/%h exp 0", i, b1.rs1_data, b0.rs2_data); else pass_cnt++;
            total++; if (b1.rs1_busy !== 1'b0) $display("FAIL cleared_busy_x%0d got %b exp 0", i, b1.rs1_busy); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the RISC-V core, with a per-register scoreboard of pending writebacks.
- Adds optional write-to-read bypass and a post-reset sequential clear FSM, so the storage array can map to RAM without a reset on every entry.
- Sits between the decode/issue stage, which reads operands and marks destinations busy, and the writeback stage, which writes results and clears busy bits.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers; power of 2, at least 2; AW = clog2(NREG)
BYPASS, 1, 1 = a same-cycle writeback is forwarded to the read ports; 0 = the read sees the old value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ready  out  1  high once the clear sequence has finished
rs1  in  AW  read port 1 address
rs2  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  register rs1 has a pending writeback
rs2_busy  out  1  register rs2 has a pending writeback
we  in  1  writeback enable
rd  in  AW  writeback address
rd_data  in  XLEN  writeback data
iss_valid  in  1  issue: mark iss_rd busy
iss_rd  in  AW  issue destination address
busy_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Reset (asynchronous, any time, including mid-clear or mid-run):
  - state=CLEAR, clr_idx=0, all busy bits=0, busy_cnt=0, ready=0.
  - Array contents are not reset directly.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Each clock writes 0 to x[clr_idx] and increments clr_idx.
  - The edge that writes x[NREG-1] moves the state to RUN.
  - ready rises on that same edge, NREG cycles after reset release.
  - we and iss_valid are ignored in CLEAR.
  - rs1_data/rs2_data read 0; rs1_busy/rs2_busy read 0.
- RUN state is terminal until the next reset.
- Write (RUN): on a clock with we=1 and rd!=0, x[rd] <= rd_data. Writes to x0 are discarded.
- Read (RUN, combinational):
  - rsN==0 reads 0.
  - Otherwise, if BYPASS=1 and we=1 and rd==rsN (rd!=0), rsN_data = rd_data.
  - Otherwise rsN_data = x[rsN].
- Scoreboard (RUN), evaluated at each clock edge:
  - set = iss_valid && iss_rd!=0.
  - clr = we && rd!=0.
  - set marks busy[iss_rd]=1; clr marks busy[rd]=0.
  - set and clr on the same register: set wins and busy stays 1 (a new producer is issued as the old one retires).
  - Writeback to a non-busy register is legal (untracked producer); busy stays 0.
  - Re-issue to an already-busy register leaves it busy.
  - x0 is never busy.
- Busy outputs:
  - rsN_busy = busy[rsN] && !(BYPASS && clr && rd==rsN && !(set && iss_rd==rsN)).
  - With BYPASS=1, an operand retiring this cycle is reported ready and its data is taken from the bypass.
- busy_cnt:
  - +1 for each register going 0->1; -1 for each register going 1->0, both on the same edge.
  - Range 0..NREG-1; always equals the popcount of busy[].

Test Plan:
- Reset, then release with NREG=32 -> ready=0 for 32 cycles and 1 in cycle 33; x5 reads 0; we=1 pulsed during CLEAR changes nothing.
- RUN: write rd=3, data 0xDEADBEEF -> next cycle rs1=3 reads 0xDEADBEEF; write rd=0, data 0x1234 -> rs2=0 reads 0.
- BYPASS=1: same cycle we=1, rd=7, rd_data=0xA5A5A5A5, rs1=7 -> rs1_data=0xA5A5A5A5 combinationally. BYPASS=0: rs1_data is the old x7 until the next cycle.
- Issue iss_rd=4 -> rs2=4 gives rs2_busy=1 and busy_cnt=1. Writeback rd=4 -> busy clears, busy_cnt=0. Simultaneous issue and writeback of x9 while x9 is busy -> busy stays 1 and busy_cnt is unchanged.
- Issue x1, x2, x3 on consecutive cycles, then writeback x2 while issuing x6 -> busy_cnt goes 1, 2, 3, 3. iss_rd=0 -> busy_cnt unchanged.
- Assert rst mid-RUN with 3 registers busy -> busy_cnt=0 and ready=0 immediately (asynchronous); the clear sequence restarts and every register reads 0 once ready rises.
